uart_core: RTL

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 rtl/uart_core.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART core.
//   parity_t               : parity mode selector (none / odd / even)
//   tx_state_t, rx_state_t : transmitter and receiver FSM state encodings
//   DEFAULT_CYCLES_PER_BIT : 24 MHz clock / 1200 baud
//   parity_bit()           : parity bit for a given data XOR and mode
package uart_pkg;

  localparam int DEFAULT_CYCLES_PER_BIT = 20000;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_ODD,
    PARITY_EVEN
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Even parity is the plain XOR of the data; odd parity is its inverse.
  function automatic logic parity_bit(input parity_t mode, input logic data_xor);
    return data_xor ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx -- UART receiver: 2-flop input synchronizer plus receive FSM.
// Ports:
//   clk, rst (async, active-high)
//   ser_rx        : serial line in, asynchronous to clk
//   rx_data       : last received word, held until the next rx_valid
//   rx_valid      : one-cycle pulse, data and error flags valid
//   rx_parity_err : parity mismatch on the flagged frame
//   rx_frame_err  : first stop bit sampled low on the flagged frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int      CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int      DATA_BITS      = 8,
  parameter parity_t PARITY         = PARITY_NONE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ser_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_d;
  logic                 rx_valid_d, rx_parity_err_d, rx_frame_err_d;

  // Synchronizer resets to the idle-high line level so reset never looks
  // like a start bit.
  assign rx_s = sync_q[1];

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would make the synchronizer
  // collapse into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= 2'b11;
      state_q       <= RX_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], ser_rx};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      rx_data       <= rx_data_d;
      rx_valid      <= rx_valid_d;
      rx_parity_err <= rx_parity_err_d;
      rx_frame_err  <= rx_frame_err_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    par_d           = par_q;
    rx_data_d       = rx_data;
    rx_valid_d      = 1'b0;
    rx_parity_err_d = rx_parity_err;
    rx_frame_err_d  = rx_frame_err;

    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end

      // Resample mid start bit; a line that is already high again was a glitch.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // LSB arrives first, so shift in from the top.
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Only the first stop bit is checked; the word is delivered regardless.
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d           = '0;
          rx_valid_d      = 1'b1;
          rx_data_d       = shift_q;
          rx_parity_err_d = (PARITY != PARITY_NONE) &&
                            (par_q != parity_bit(PARITY, ^shift_q));
          rx_frame_err_d  = !rx_s;
          state_d         = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Break handling: a held-low line must not be taken as a new start bit.
      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end

      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_core.sv
// uart_core -- full-duplex UART: inline transmitter plus uart_rx receiver.
// Ports:
//   clk, rst (async, active-high)
//   tx_data/tx_valid/tx_ready : transmit handshake, word latched on accept
//   ser_tx                    : registered serial out, idle high
//   ser_rx                    : serial in, asynchronous to clk
//   rx_data/rx_valid          : received word with one-cycle valid pulse
//   rx_parity_err/rx_frame_err: error flags qualified by rx_valid
module uart_core
  import uart_pkg::*;
#(
  parameter int      CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int      DATA_BITS      = 8,
  parameter parity_t PARITY         = PARITY_NONE,
  parameter int      STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 ser_tx,
  input  logic                 ser_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
  logic                 tx_stop_q, tx_stop_d;
  logic [DATA_BITS-1:0] tx_word_q, tx_word_d;
  logic                 ser_tx_d;
  logic                 tx_ready_d;
  logic                 bit_done;

  assign bit_done = (tx_cnt_q == BIT_LAST);

  // tx_ready is registered so it stays low through reset and rises on the
  // first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_word_q  <= '0;
      ser_tx     <= 1'b1;
      tx_ready   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_stop_q  <= tx_stop_d;
      tx_word_q  <= tx_word_d;
      ser_tx     <= ser_tx_d;
      tx_ready   <= tx_ready_d;
    end
  end

  // ser_tx_d is the level for the next cycle, so each transition loads the
  // first level of the state being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_stop_d  = tx_stop_q;
    tx_word_d  = tx_word_q;
    ser_tx_d   = ser_tx;

    unique case (tx_state_q)
      TX_IDLE: begin
        ser_tx_d = 1'b1;
        if (tx_valid && tx_ready) begin
          tx_word_d  = tx_data;
          tx_cnt_d   = '0;
          ser_tx_d   = 1'b0;
          tx_state_d = TX_START;
        end
      end

      TX_START: begin
        if (bit_done) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          ser_tx_d   = tx_word_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end

      TX_DATA: begin
        if (bit_done) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) begin
            if (PARITY == PARITY_NONE) begin
              tx_stop_d  = 1'b0;
              ser_tx_d   = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              ser_tx_d   = parity_bit(PARITY, ^tx_word_q);
              tx_state_d = TX_PARITY;
            end
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            ser_tx_d = tx_word_q[tx_idx_d];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end

      TX_PARITY: begin
        if (bit_done) begin
          tx_cnt_d   = '0;
          tx_stop_d  = 1'b0;
          ser_tx_d   = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end

      TX_STOP: begin
        ser_tx_d = 1'b1;
        if (bit_done) begin
          tx_cnt_d = '0;
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_stop_d = tx_stop_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end

      default: begin
        ser_tx_d   = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase

    tx_ready_d = (tx_state_d == TX_IDLE);
  end

  uart_rx #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT),
    .DATA_BITS     (DATA_BITS),
    .PARITY        (PARITY)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err)
  );

endmodule
